adder_reg_10bits: RTL and testbench

- 10-bit datapath element: a combinational 10-bit adder with carry-in/carry-out, plus a 10-bit write-enabled state register that captures the adder sum.
- Serves as the program-counter core of the fetch path.
  - The surrounding fetch logic drives the adder operands (current PC plus 1, jump offset, or return address plus 0).
  - The register output is the instruction-memory read address.

---
 rtl/adder_reg_10bits_pkg.sv | 6 +
 rtl/adder_reg_10bits_full_adder_1bit.sv | 11 +
 rtl/adder_reg_10bits.sv | 30 +++
 tb/tb_adder_reg_10bits.sv | 117 +++++++++++
 4 files changed

// File: rtl/adder_reg_10bits_pkg.sv
// adder_reg_10bits_pkg: shared width, reset value and PC type for the fetch-path PC core
package adder_reg_10bits_pkg;
  localparam int WIDTH = 10;
  typedef logic [WIDTH-1:0] pc_t;
  localparam pc_t RESET_VALUE = 10'h000;
endpackage

// File: rtl/adder_reg_10bits_full_adder_1bit.sv
// full_adder_1bit: one ripple-carry cell; a,b,ci in -> s sum bit, co carry out
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder_reg_10bits.sv
// adder_reg_10bits: PC core; sum/cout = a+b+cin (ripple), q captures sum on clk when wen, async active-low rst
module adder_reg_10bits
  import adder_reg_10bits_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  pc_t  a,
  input  pc_t  b,
  input  logic cin,
  input  logic wen,
  output pc_t  sum,
  output logic cout,
  output pc_t  q
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (sum[i]),
      .co(c[i+1])
    );
  end
  assign cout = c[WIDTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RESET_VALUE;
    else if (wen) q <= sum;
endmodule

// File: tb/tb_adder_reg_10bits.sv
// tb_adder_reg_10bits: directed and random checks of adder_reg_10bits against an arithmetic reference
module tb_adder_reg_10bits;
  logic clk = 0, rst = 0, cin = 0, wen = 0, tie = 0, go = 0;
  logic [9:0] a_reg = 0, b = 0, sum, q, mq = 0;
  logic [9:0] a_w;
  logic cout;
  int checks = 0, errors = 0;

  assign a_w = tie ? q : a_reg;

  adder_reg_10bits dut (
    .clk (clk),
    .rst (rst),
    .a   (a_w),
    .b   (b),
    .cin (cin),
    .wen (wen),
    .sum (sum),
    .cout(cout),
    .q   (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference register: the 11-bit true sum truncated to 10 bits, cleared whenever reset is low
  always @(posedge clk) if (rst && wen) mq = 10'((11'(a_w) + 11'(b) + 11'(cin)) % 1024);
  always @(negedge rst) mq = 10'h000;

  always @(negedge clk) if (go) begin
    logic [10:0] t;
    t = 11'(a_w) + 11'(b) + 11'(cin);
    chk("cyc_sum", {1'b0, sum}, {1'b0, t[9:0]});
    chk("cyc_cout", {10'b0, cout}, {10'b0, t[10]});
    chk("cyc_q", {1'b0, q}, {1'b0, rst ? mq : 10'h000});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] av, input logic [9:0] bv, input logic c, input logic w);
    a_reg = av; b = bv; cin = c; wen = w;
  endtask

  initial begin
    logic [9:0] ra, rb;
    logic rc;
    logic [10:0] rt;
    tick; tick;
    go = 1;
    chk("reset_q", {1'b0, q}, 11'h000);
    rst = 1;
    drive(10'h155, 10'h000, 0, 1); tick;
    chk("load_155", {1'b0, q}, 11'h155);
    #2 rst = 0; #1;
    chk("async_reset", {1'b0, q}, 11'h000);
    tick;
    chk("reset_hold", {1'b0, q}, 11'h000);
    rst = 1;
    drive(10'h000, 10'h001, 0, 1); tick;
    chk("first_after_reset", {1'b0, q}, 11'h001);
    rst = 0; tick; rst = 1;
    tie = 1; drive(10'h000, 10'h001, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk("incr", {1'b0, q}, 11'(i));
    end
    tie = 0;
    drive(10'h3FF, 10'h001, 0, 1); #1;
    chk("wrap_sum", {cout, sum}, 11'h400);
    tick;
    chk("wrap_q", {1'b0, q}, 11'h000);
    drive(10'h0FF, 10'h000, 1, 0); #1;
    chk("cin_100", {cout, sum}, 11'h100);
    drive(10'h3FF, 10'h3FF, 1, 0); #1;
    chk("cin_max", {cout, sum}, 11'h7FF);
    drive(10'h010, 10'h000, 0, 1); tick;
    chk("load_010", {1'b0, q}, 11'h010);
    drive(10'h020, 10'h005, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wen_hold", {1'b0, q}, 11'h010);
    end
    wen = 1; tick;
    chk("wen_load", {1'b0, q}, 11'h025);
    for (int i = 0; i < 1000; i++) begin
      ra = 10'($urandom); rb = 10'($urandom); rc = 1'($urandom);
      drive(ra, rb, rc, 1'($urandom)); #1;
      rt = 11'(ra) + 11'(rb) + 11'(rc);
      chk("rand_add", {cout, sum}, rt);
      tick;
    end
    drive(10'h123, 10'h111, 1, 1);
    @(posedge clk);
    rst = 0;
    #1;
    chk("reset_on_edge", {1'b0, q}, 11'h000);
    tick;
    chk("reset_on_edge_hold", {1'b0, q}, 11'h000);
    rst = 1;
    tick;
    chk("after_edge_reset", {1'b0, q}, 11'h235);
    tick;
    go = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
